// File: rtl/gate_unit_pipe_pkg.sv
// gate_unit_pipe_pkg: opcodes and default sizes shared by the gate unit files
package gate_unit_pipe_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 16;
  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_NAND = 3'b001,
    OP_OR   = 3'b010,
    OP_NOR  = 3'b011,
    OP_XOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOTA = 3'b110,
    OP_PASS = 3'b111
  } op_e;
endpackage

// File: rtl/gate_unit_pipe_gate_op.sv
// gate_op: combinational bitwise gate selected by a 3-bit opcode
module gate_op
  import gate_unit_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s
);
  // apply the selected gate to every bit pair
  always_comb begin
    s = a;
    case (op_e'(op))
      OP_AND:  s = a & b;
      OP_NAND: s = ~(a & b);
      OP_OR:   s = a | b;
      OP_NOR:  s = ~(a | b);
      OP_XOR:  s = a ^ b;
      OP_XNOR: s = ~(a ^ b);
      OP_NOTA: s = ~a;
      OP_PASS: s = a;
    endcase
  end
endmodule

// File: rtl/gate_unit_pipe.sv
// gate_unit_pipe: two-stage valid/ready gate pipeline with delivered-result counter
module gate_unit_pipe
  import gate_unit_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             zero,
  output logic [CNT_W-1:0] count
);
  logic             v1_q, v2_q, zero_q, acc1, acc2;
  logic [2:0]       op1_q;
  logic [WIDTH-1:0] a1_q, b1_q, s_q, f_d;
  logic [CNT_W-1:0] count_q, count_d;
  gate_op #(.WIDTH(WIDTH)) u_gate_op (.op(op1_q), .a(a1_q), .b(b1_q), .s(f_d));
  // ready chain: a stage accepts when empty or when the stage after it moves
  always_comb begin
    acc2    = !v2_q || out_ready;
    acc1    = !v1_q || acc2;
    count_d = count_q + CNT_W'(1);
  end
  // stage 1 captures operands on an input handshake, otherwise holds
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q  <= 1'b0;
      op1_q <= 3'b000;
      a1_q  <= '0;
      b1_q  <= '0;
    end else if (acc1) begin
      v1_q <= in_valid;
      if (in_valid) begin
        op1_q <= op;
        a1_q  <= a;
        b1_q  <= b;
      end
    end
  end
  // stage 2 captures the gate result and its zero flag when stage 1 advances
  always_ff @(posedge clk) begin
    if (reset) begin
      v2_q   <= 1'b0;
      s_q    <= '0;
      zero_q <= 1'b1;
    end else if (acc2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        s_q    <= f_d;
        zero_q <= ~|f_d;
      end
    end
  end
  // count delivered results on the output handshake edge, wrapping naturally
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else if (v2_q && out_ready) count_q <= count_d;
  end
  assign in_ready  = acc1;
  assign out_valid = v2_q;
  assign s         = s_q;
  assign zero      = zero_q;
  assign count     = count_q;
endmodule

// File: tb/tb_gate_unit_pipe.sv
// tb_gate_unit_pipe: directed and random checks of gate_unit_pipe against a truth-table scoreboard
module tb_gate_unit_pipe;
  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready;
  logic        in_ready, out_valid, zero, in_ready2, out_valid2, zero2;
  logic [2:0]  op;
  logic [3:0]  a, b, s, s2;
  logic [15:0] count;
  logic [1:0]  count2;
  int errors = 0;
  int checks = 0;
  logic [4:0]  q[$];
  logic [15:0] exp_cnt;
  logic [1:0]  exp_cnt2;
  logic [3:0]  tt [8] = '{4'b1000, 4'b0111, 4'b1110, 4'b0001, 4'b0110, 4'b1001, 4'b0011, 4'b1100};
  logic [3:0]  tt_exp [8] = '{4'b1000, 4'b0111, 4'b1110, 4'b0001, 4'b0110, 4'b1001, 4'b0011, 4'b1100};
  logic [1:0]  w2_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [4:0]  m0, m1, m2;
  gate_unit_pipe #(.WIDTH(4), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .zero(zero), .count(count)
  );
  gate_unit_pipe #(.WIDTH(4), .CNT_W(2)) u_w2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2), .op(op), .a(a), .b(b),
    .out_valid(out_valid2), .out_ready(out_ready), .s(s2), .zero(zero2), .count(count2)
  );
  always #5 clk = ~clk;
  // each result bit is the opcode's two-input truth table looked up at {a_bit, b_bit}
  function automatic logic [4:0] model(logic [2:0] o, logic [3:0] x, logic [3:0] y);
    logic [3:0] r;
    logic [3:0] t;
    t = tt[o];
    for (int i = 0; i < 4; i++) r[i] = t[{x[i], y[i]}];
    return {r == 4'd0, r};
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic rnd_in();
    op = 3'($urandom);
    a  = 4'($urandom);
    b  = 4'($urandom);
  endtask
  // one clock: score outputs and handshakes before the edge, check counters after it
  task automatic cyc();
    @(negedge clk);
    if (reset) begin
      q.delete();
      exp_cnt  = '0;
      exp_cnt2 = '0;
    end else begin
      chk("in_ready", in_ready, !(q.size() == 2 && !out_ready));
      if (q.size() == 0) chk("idle_valid", out_valid, 0);
      if (out_valid && q.size() > 0) begin
        chk("s", s, q[0][3:0]);
        chk("zero", zero, q[0][4]);
      end
      if (out_valid && out_ready && q.size() > 0) begin
        void'(q.pop_front());
        exp_cnt++;
        exp_cnt2++;
      end
      if (in_valid && in_ready) q.push_back(model(op, a, b));
    end
    @(posedge clk);
    #1;
    chk("count", count, exp_cnt);
    chk("count_w2", count2, exp_cnt2);
  endtask
  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    cyc(); cyc();
    reset = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_s", s, 0);
    chk("rst_zero", zero, 1);
    chk("rst_count", count, 0);
    chk("rst_ready", in_ready, 1);
    out_ready = 1'b1; a = 4'b1100; b = 4'b1010;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 8);
      op = 3'(c);
      cyc();
      if (c == 0) chk("tt_latency", out_valid, 0);
      if (c >= 1 && c <= 8) begin
        chk("tt_valid", out_valid, 1);
        chk("tt_s", s, tt_exp[c-1]);
        chk("tt_zero", zero, 0);
      end
    end
    chk("tt_count", count, 8);
    out_ready = 1'b0; in_valid = 1'b1;
    rnd_in(); m0 = model(op, a, b); cyc();
    rnd_in(); m1 = model(op, a, b); cyc();
    chk("stall_ready", in_ready, 0);
    chk("stall_s0", s, m0[3:0]);
    rnd_in(); m2 = model(op, a, b); cyc();
    chk("stall_ready2", in_ready, 0);
    chk("stall_hold", s, m0[3:0]);
    out_ready = 1'b1; cyc();
    in_valid = 1'b0;
    chk("drain_b_valid", out_valid, 1);
    chk("drain_b_s", s, m1[3:0]);
    cyc();
    chk("drain_c_valid", out_valid, 1);
    chk("drain_c_s", s, m2[3:0]);
    cyc();
    chk("drain_done", out_valid, 0);
    in_valid = 1'b1; op = 3'b000; a = 4'b0101; b = 4'b1010; cyc();
    op = 3'b011; a = 4'b1111; b = 4'b1111; cyc();
    in_valid = 1'b0;
    chk("and_s", s, 0);
    chk("and_zero", zero, 1);
    cyc();
    chk("nor_s", s, 0);
    chk("nor_zero", zero, 1);
    cyc();
    reset = 1'b1; cyc(); reset = 1'b0;
    for (int k = 0; k < 7; k++) begin
      in_valid = (k < 5);
      rnd_in();
      cyc();
      if (k >= 2) chk("wrap_seq", count2, w2_exp[k-2]);
    end
    out_ready = 1'b0; in_valid = 1'b1;
    rnd_in(); cyc();
    rnd_in(); cyc();
    in_valid = 1'b0; reset = 1'b1; cyc(); reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("midrst_valid", out_valid, 0);
      chk("midrst_count", count, 0);
    end
    out_ready = 1'b1; in_valid = 1'b1; rnd_in(); m0 = model(op, a, b); cyc();
    in_valid = 1'b0;
    chk("fresh_lat", out_valid, 0);
    cyc();
    chk("fresh_valid", out_valid, 1);
    chk("fresh_s", s, m0[3:0]);
    for (int k = 0; k < 400; k++) begin
      in_valid = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rnd_in();
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) cyc();
    chk("final_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
